// File: rtl/apb_arbiter_if.sv
// APB4 bus bundle shared between the arbiter (master side) and the decoder/slaves.
interface ApbIO #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [2:0]              pprot;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   modport master (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB4 master port among N_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abandon ACCESS phases that exceed TIMEOUT cycles.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module apb_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned ADDR_WIDTH = `PADDR_SIZE,
   parameter int unsigned DATA_WIDTH = `XLEN,
   parameter int unsigned TIMEOUT    = 256
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [N_REQ*3-1:0]            req_prot,
   input  logic [N_REQ-1:0]              req_write,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
   input  logic [N_REQ*DATA_WIDTH/8-1:0] req_strb,
   output logic [N_REQ-1:0]              resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_rdata,
   output logic                          resp_err,
   ApbIO.master                          apb
);
   localparam int unsigned PTR_W  = $clog2(N_REQ);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   if (N_REQ < 2 || TIMEOUT < 1) begin : g_param_check
      $error("apb_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
   end

   logic [1:0]            state;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      grant_id;
   logic [PTR_W-1:0]      winner;
   logic [PTR_W:0]        scan;
   logic                  any_valid;

   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [2:0]            sel_prot;
   logic                  sel_write;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [STRB_W-1:0]     sel_strb;

   logic                  xfer_done;
   logic                  xfer_err;
   logic [DATA_WIDTH-1:0] xfer_rdata;

   // Scan starting at rr_ptr; scan is one bit wider so the wrap subtraction cannot overflow.
   always_comb begin
      winner    = rr_ptr;
      any_valid = 1'b0;
      scan      = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (scan >= (PTR_W+1)'(N_REQ)) scan = scan - (PTR_W+1)'(N_REQ);
         if (!any_valid && req_valid[scan[PTR_W-1:0]]) begin
            any_valid = 1'b1;
            winner    = scan[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst && state == IDLE && any_valid) req_ready[winner] = 1'b1;
   end

   always_comb begin
      sel_addr  = '0;
      sel_prot  = '0;
      sel_write = 1'b0;
      sel_wdata = '0;
      sel_strb  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (PTR_W'(i) == winner) begin
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_prot  = req_prot[i*3 +: 3];
            sel_write = req_write[i];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_strb  = req_strb[i*STRB_W +: STRB_W];
         end
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        tmo_hit;

   assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));
`endif

   always_comb begin
      xfer_done  = apb.pready;
      xfer_err   = apb.pslverr;
      xfer_rdata = apb.pwrite ? '0 : apb.prdata;
`ifdef APB_ARB_TIMEOUT_EN
      // The cycle that would be the TIMEOUT-th stalled one ends the transfer with an error.
      if (!apb.pready && tmo_hit) begin
         xfer_done  = 1'b1;
         xfer_err   = 1'b1;
         xfer_rdata = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         apb.paddr   <= '0;
         apb.pprot   <= '0;
         apb.pwdata  <= '0;
         apb.pstrb   <= '0;
         resp_valid  <= '0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         resp_valid <= '0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_id    <= winner;
                  rr_ptr      <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                  apb.paddr   <= sel_addr;
                  apb.pprot   <= sel_prot;
                  apb.pwrite  <= sel_write;
                  apb.pwdata  <= sel_wdata;
                  apb.pstrb   <= sel_write ? sel_strb : '0;
                  apb.psel    <= 1'b1;
                  apb.penable <= 1'b0;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               apb.penable <= 1'b1;
               state       <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
               tmo_cnt     <= '0;
`endif
            end
            ACCESS: begin
               if (xfer_done) begin
                  resp_valid[grant_id] <= 1'b1;
                  resp_rdata           <= xfer_rdata;
                  resp_err             <= xfer_err;
                  apb.psel             <= 1'b0;
                  apb.penable          <= 1'b0;
                  state                <= IDLE;
               end
`ifdef APB_ARB_TIMEOUT_EN
               else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            default: begin
               apb.psel    <= 1'b0;
               apb.penable <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_arbiter.sv
// Directed testbench for apb_arbiter (N_REQ=4, 32-bit bus, TIMEOUT=8).
module tb_apb_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_write = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      resp_valid;
   logic [N*AW-1:0]   req_addr  = '0;
   logic [N*3-1:0]    req_prot  = '0;
   logic [N*DW-1:0]   req_wdata = '0;
   logic [N*DW/8-1:0] req_strb  = '0;
   logic [DW-1:0]     resp_rdata;
   logic              resp_err;
   logic [N-1:0]      exp_oh;
   int                n_assert = 0;
   int                n_fail   = 0;

   ApbIO #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_bus ();

   apb_arbiter #(
      .N_REQ      (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_prot   (req_prot),
      .req_write  (req_write),
      .req_wdata  (req_wdata),
      .req_strb   (req_strb),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .apb        (apb_bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
      req_addr[i*AW +: AW]   = addr;
      req_write[i]           = wr;
      req_wdata[i*DW +: DW]  = wd;
      req_strb[i*4 +: 4]     = st;
      req_prot[i*3 +: 3]     = pr;
   endtask

   initial begin
      apb_bus.pready  = 1'b0;
      apb_bus.prdata  = '0;
      apb_bus.pslverr = 1'b0;

      // Reset with every requester asking
      rst = 1'b0;
      req_valid = 4'hF;
      step();
      step();
      check("rst_psel", apb_bus.psel, 0);
      check("rst_penable", apb_bus.penable, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_paddr", apb_bus.paddr, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      rst = 1'b1;
      #1;
      check("rr_ptr_zero", req_ready, 4'b0001);

      // Single write from requester 0, immediate pready
      set_req(0, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010);
      req_valid = 4'b0001;
      step();
      check("wr_setup_psel", apb_bus.psel, 1);
      check("wr_setup_penable", apb_bus.penable, 0);
      check("wr_paddr", apb_bus.paddr, 32'h1000);
      check("wr_pwrite", apb_bus.pwrite, 1);
      check("wr_pwdata", apb_bus.pwdata, 32'hDEADBEEF);
      check("wr_pstrb", apb_bus.pstrb, 4'hF);
      check("wr_pprot", apb_bus.pprot, 3'b010);
      check("wr_ready_busy", req_ready, 0);
      req_valid = '0;
      apb_bus.pready = 1'b1;
      step();
      check("wr_access_penable", apb_bus.penable, 1);
      check("wr_access_paddr", apb_bus.paddr, 32'h1000);
      step();
      check("wr_resp_valid", resp_valid, 4'b0001);
      check("wr_resp_err", resp_err, 0);
      check("wr_resp_rdata", resp_rdata, 0);
      check("wr_resp_psel", apb_bus.psel, 0);

      // Read from requester 2 with three wait states
      set_req(2, 32'h2004, 1'b0, 32'hCAFEF00D, 4'hF, 3'b000);
      req_valid = 4'b0100;
      apb_bus.pready = 1'b0;
      apb_bus.prdata = 32'hBAD0BAD0;
      #1;
      check("rd_ready", req_ready, 4'b0100);
      step();
      check("rd_paddr", apb_bus.paddr, 32'h2004);
      check("rd_pwrite", apb_bus.pwrite, 0);
      check("rd_pstrb_setup", apb_bus.pstrb, 0);
      req_valid = '0;
      step();
      check("rd_acc1_penable", apb_bus.penable, 1);
      check("rd_acc1_pstrb", apb_bus.pstrb, 0);
      step();
      check("rd_acc2_psel", apb_bus.psel, 1);
      check("rd_acc2_resp", resp_valid, 0);
      step();
      check("rd_acc3_penable", apb_bus.penable, 1);
      step();
      check("rd_acc4_resp", resp_valid, 0);
      apb_bus.pready = 1'b1;
      apb_bus.prdata = 32'h12345678;
      step();
      check("rd_resp_valid", resp_valid, 4'b0100);
      check("rd_resp_rdata", resp_rdata, 32'h12345678);
      check("rd_resp_err", resp_err, 0);

      // Reset in the middle of an ACCESS phase
      apb_bus.pready = 1'b0;
      set_req(3, 32'h5000, 1'b1, 32'h0000AAAA, 4'h3, 3'b001);
      req_valid = 4'b1000;
      #1;
      check("rr_next_is_3", req_ready, 4'b1000);
      step();
      req_valid = '0;
      step();
      check("abort_in_access", apb_bus.penable, 1);
      rst = 1'b0;
      apb_bus.pready = 1'b1;
      req_valid = 4'hF;
      step();
      check("abort_psel", apb_bus.psel, 0);
      check("abort_penable", apb_bus.penable, 0);
      check("abort_resp", resp_valid, 0);
      check("abort_paddr", apb_bus.paddr, 0);
      check("abort_ready", req_ready, 0);
      rst = 1'b1;
      req_valid = '0;
      step();
      check("abort_no_resp", resp_valid, 0);
      check("abort_idle_psel", apb_bus.psel, 0);

      // Fairness: all requesters held valid, slot 3 answers with pslverr
      for (int i = 0; i < 4; i++) set_req(i, 32'h100 * (i + 1), 1'b0, 32'h0, 4'hF, 3'(i));
      req_valid = 4'hF;
      #1;
      for (int t = 0; t < 5; t++) begin
         exp_oh = 4'b0001 << (t % 4);
         check("rr_ready", req_ready, exp_oh);
         step();
         check("rr_paddr", apb_bus.paddr, 32'h100 * ((t % 4) + 1));
         check("rr_pprot", apb_bus.pprot, 3'(t % 4));
         apb_bus.pready  = 1'b1;
         apb_bus.pslverr = ((t % 4) == 3);
         apb_bus.prdata  = 32'hA000 + t;
         step();
         check("rr_penable", apb_bus.penable, 1);
         step();
         check("rr_resp_valid", resp_valid, exp_oh);
         check("rr_resp_err", resp_err, ((t % 4) == 3) ? 1 : 0);
         check("rr_resp_rdata", resp_rdata, 32'hA000 + t);
         check("rr_resp_psel", apb_bus.psel, 0);
      end
      req_valid = '0;
      apb_bus.pslverr = 1'b0;

      // Back-to-back: requester 1 re-requests in its own response cycle
      set_req(1, 32'h3000, 1'b1, 32'h11111111, 4'hF, 3'b000);
      req_valid = 4'b0010;
      #1;
      check("b2b_ready1", req_ready, 4'b0010);
      step();
      step();
      step();
      check("b2b_resp1", resp_valid, 4'b0010);
      check("b2b_gap_psel", apb_bus.psel, 0);
      set_req(1, 32'h3004, 1'b1, 32'h22222222, 4'hF, 3'b000);
      #1;
      check("b2b_ready2", req_ready, 4'b0010);
      step();
      check("b2b_psel_back", apb_bus.psel, 1);
      check("b2b_paddr2", apb_bus.paddr, 32'h3004);
      check("b2b_penable2", apb_bus.penable, 0);
      req_valid = '0;
      step();
      step();
      check("b2b_resp2", resp_valid, 4'b0010);

      // Stuck slave: pready never rises
      set_req(0, 32'h4000, 1'b0, 32'h0, 4'hF, 3'b000);
      req_valid = 4'b0001;
      apb_bus.pready = 1'b0;
      apb_bus.prdata = 32'hFFFFFFFF;
      #1;
      check("tmo_ready", req_ready, 4'b0001);
      step();
      req_valid = '0;
      step();
      for (int c = 0; c < 7; c++) begin
         step();
         check("tmo_wait_psel", apb_bus.psel, 1);
      end
      step();
`ifdef APB_ARB_TIMEOUT_EN
      check("tmo_psel", apb_bus.psel, 0);
      check("tmo_penable", apb_bus.penable, 0);
      check("tmo_resp_valid", resp_valid, 4'b0001);
      check("tmo_resp_err", resp_err, 1);
      check("tmo_resp_rdata", resp_rdata, 0);
`else
      check("notmo_psel", apb_bus.psel, 1);
      check("notmo_penable", apb_bus.penable, 1);
      check("notmo_resp", resp_valid, 0);
      apb_bus.prdata = 32'h55;
      apb_bus.pready = 1'b1;
      step();
      check("late_resp_valid", resp_valid, 4'b0001);
      check("late_resp_rdata", resp_rdata, 32'h55);
      check("late_resp_err", resp_err, 0);
`endif
      apb_bus.pready = 1'b0;
      step();
      check("resp_one_cycle", resp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
